// File: rtl/ped_crossing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ped_crossing_ctrl
// Description : Pedestrian WALK / flashing DONT_WALK sequencer gated by the
//               vehicle RED interval of the upstream traffic light FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module ped_crossing_ctrl #(
    parameter int WALK_TICKS  = 4,
    parameter int FLASH_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] light,
    input  logic       tick,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic [3:0] countdown,
    output logic       req_pending,
    output logic       req_ack,
    output logic       abort,
    output logic       fault
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WALK  = 2'd1;
    localparam logic [1:0] c_ST_FLASH = 2'd2;

    localparam logic [2:0] c_RED    = 3'b100;
    localparam logic [2:0] c_GREEN  = 3'b001;
    localparam logic [2:0] c_YELLOW = 3'b010;

    localparam logic [3:0] c_WALK_LOAD  = 4'(WALK_TICKS);
    localparam logic [3:0] c_FLASH_LOAD = 4'(FLASH_TICKS);

    logic       r_s1, r_s2, r_s3;
    logic [2:0] r_light_q;
    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_flash_ph;
    logic       r_req_pending;
    logic       r_req_ack;
    logic       r_abort;
    logic       r_fault;
    logic       r_walk;
    logic       r_dont_walk;

    logic       w_press;
    logic       w_is_red;
    logic       w_illegal;
    logic       w_red_entry;
    logic [1:0] w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_ph_nxt;
    logic       w_ack_nxt;
    logic       w_abort_nxt;
    logic       w_walk_nxt;
    logic       w_dont_walk_nxt;

    assign w_press     = r_s2 & ~r_s3;
    assign w_is_red    = (light == c_RED);
    assign w_illegal   = (light != c_RED) && (light != c_GREEN) && (light != c_YELLOW);
    assign w_red_entry = w_is_red && (r_light_q != c_RED) && !w_illegal;

    // Leaving RED (including any illegal code) preempts tick-driven countdown.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ph_nxt    = r_flash_ph;
        w_ack_nxt   = 1'b0;
        w_abort_nxt = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_red_entry && r_req_pending) begin
                    w_state_nxt = c_ST_WALK;
                    w_cnt_nxt   = c_WALK_LOAD;
                    w_ack_nxt   = 1'b1;
                end
            end
            c_ST_WALK: begin
                if (!w_is_red) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_ph_nxt    = 1'b0;
                    w_abort_nxt = 1'b1;
                end else if (tick) begin
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = c_ST_FLASH;
                        w_cnt_nxt   = c_FLASH_LOAD;
                        w_ph_nxt    = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
            c_ST_FLASH: begin
                if (!w_is_red) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_ph_nxt    = 1'b0;
                    w_abort_nxt = 1'b1;
                end else if (tick) begin
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = 4'd0;
                        w_ph_nxt    = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                        w_ph_nxt  = ~r_flash_ph;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 4'd0;
                w_ph_nxt    = 1'b0;
            end
        endcase

        w_walk_nxt      = (w_state_nxt == c_ST_WALK);
        w_dont_walk_nxt = (w_state_nxt == c_ST_IDLE) ||
                          ((w_state_nxt == c_ST_FLASH) && w_ph_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1          <= 1'b0;
            r_s2          <= 1'b0;
            r_s3          <= 1'b0;
            r_light_q     <= 3'b000;
            r_state       <= c_ST_IDLE;
            r_cnt         <= 4'd0;
            r_flash_ph    <= 1'b0;
            r_req_pending <= 1'b0;
            r_req_ack     <= 1'b0;
            r_abort       <= 1'b0;
            r_fault       <= 1'b0;
            r_walk        <= 1'b0;
            r_dont_walk   <= 1'b1;
        end else begin
            r_s1          <= ped_btn;
            r_s2          <= r_s1;
            r_s3          <= r_s2;
            r_light_q     <= light;
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_flash_ph    <= w_ph_nxt;
            // A press landing on the grant edge stays pending.
            r_req_pending <= w_press | (r_req_pending & ~w_ack_nxt);
            r_req_ack     <= w_ack_nxt;
            r_abort       <= w_abort_nxt;
            r_fault       <= w_illegal;
            r_walk        <= w_walk_nxt;
            r_dont_walk   <= w_dont_walk_nxt;
        end
    end

    assign walk        = r_walk;
    assign dont_walk   = r_dont_walk;
    assign countdown   = r_cnt;
    assign req_pending = r_req_pending;
    assign req_ack     = r_req_ack;
    assign abort       = r_abort;
    assign fault       = r_fault;

endmodule
`default_nettype wire
